// File: rtl/atributos_pkg.sv
// Shared estado codes and default parameters for the attribute controller.
// Pure declarations: no timing, no handshake.
package atributos_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      DORMINDO   = 3'd1,
      COMENDO    = 3'd2,
      DANDO_AULA = 3'd3
   } estado_t;

   localparam int N_ATTR_DEF        = 3;
   localparam int W_DEF             = 8;
   localparam int TICKS_POR_SEG_DEF = 100;
   localparam int VAL_INI_DEF       = 100;
   localparam int VAL_MAX_DEF       = 100;
   localparam int INC_DEF           = 10;
   localparam int DEC_DEF           = 1;
   localparam int LIMIAR_ALERTA_DEF = 20;
   localparam int GRACA_SEG_DEF     = 3;

   // zero counters need at least one bit even when the grace period is 0
   function automatic int zc_width(input int graca);
      return (graca > 0) ? $clog2(graca + 1) : 1;
   endfunction

endpackage

// File: rtl/controlador_atributos_n_divisor.sv
// Prescaler: wraps 0..TICKS_POR_SEG-1, tick is high while the count sits at its last value.
// Latency: tick is combinational from the count register; no backpressure.
module divisor_tick
   import atributos_pkg::*;
#(
   parameter int TICKS_POR_SEG = TICKS_POR_SEG_DEF
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int            CW  = (TICKS_POR_SEG > 1) ? $clog2(TICKS_POR_SEG) : 1;
   localparam logic [CW-1:0] ULT = CW'(TICKS_POR_SEG - 1);

   if (TICKS_POR_SEG < 1) begin : g_chk_ticks
      $error("divisor_tick: TICKS_POR_SEG must be at least 1");
   end

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (cnt == ULT) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == ULT);

endmodule

// File: rtl/controlador_atributos_n.sv
// Virtual-pet attribute controller: once per prescaler period the selected attribute recharges, the rest decay.
// Latency: outputs registered, 1 cycle after the update edge; no backpressure, estado sampled only on ticks.
module controlador_atributos_n
   import atributos_pkg::*;
#(
   parameter int N_ATTR        = N_ATTR_DEF,
   parameter int W             = W_DEF,
   parameter int TICKS_POR_SEG = TICKS_POR_SEG_DEF,
   parameter int VAL_INI       = VAL_INI_DEF,
   parameter int VAL_MAX       = VAL_MAX_DEF,
   parameter int INC           = INC_DEF,
   parameter int DEC           = DEC_DEF,
   parameter int LIMIAR_ALERTA = LIMIAR_ALERTA_DEF,
   parameter int GRACA_SEG     = GRACA_SEG_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [2:0]          estado,
   output logic [N_ATTR*W-1:0] atributos,
   output logic [N_ATTR-1:0]   alerta,
   output logic                tick_seg,
   output logic                morreu
);

   localparam int            ZW         = zc_width(GRACA_SEG);
   localparam logic [W:0]    MAX_X      = (W+1)'(VAL_MAX);
   localparam logic [W:0]    INC_X      = (W+1)'(INC);
   localparam logic [W:0]    DEC_X      = (W+1)'(DEC);
   localparam logic [ZW-1:0] GRACA_X    = ZW'(GRACA_SEG);
   localparam logic          ALERTA_INI = (VAL_INI <= LIMIAR_ALERTA);

   if (VAL_INI > VAL_MAX) begin : g_chk_ini
      $error("controlador_atributos_n: VAL_INI exceeds VAL_MAX");
   end
   if (VAL_MAX >= 2**W) begin : g_chk_max
      $error("controlador_atributos_n: VAL_MAX does not fit in W bits");
   end
   if (N_ATTR > 7) begin : g_chk_n
      $error("controlador_atributos_n: estado is 3 bits, at most 7 attributes");
   end

   logic              tick;
   logic [N_ATTR-1:0] zera;

   divisor_tick #(
      .TICKS_POR_SEG(TICKS_POR_SEG)
   ) u_divisor (
      .clk (clk),
      .rst (rst),
      .tick(tick)
   );

   for (genvar i = 0; i < N_ATTR; i++) begin : g_attr
      logic [W-1:0]  val_q;
      logic [ZW-1:0] zc_q;
      logic          alerta_q;
      logic          sel;
      logic [W:0]    soma;
      logic [W:0]    nxt_x;
      logic [W-1:0]  nxt;
      logic [ZW-1:0] zc_nxt;

      // codes 0 and above N_ATTR never match, so they act as IDLE
      assign sel = (estado == 3'(i + 1));

      always_comb begin
         soma = {1'b0, val_q} + INC_X;
         if (sel) begin
            nxt_x = (soma > MAX_X) ? MAX_X : soma;
         end else begin
            nxt_x = ({1'b0, val_q} < DEC_X) ? '0 : ({1'b0, val_q} - DEC_X);
         end
         nxt = nxt_x[W-1:0];
         if (nxt != '0) begin
            zc_nxt = '0;
         end else if (zc_q == GRACA_X) begin
            zc_nxt = zc_q;
         end else begin
            zc_nxt = zc_q + 1'b1;
         end
      end

      assign zera[i] = (nxt == '0) && (zc_nxt == GRACA_X);

      always_ff @(posedge clk) begin
         if (rst) begin
            val_q    <= W'(VAL_INI);
            zc_q     <= '0;
            alerta_q <= ALERTA_INI;
         end else if (tick && !morreu) begin
            val_q    <= nxt;
            zc_q     <= zc_nxt;
            alerta_q <= (int'(nxt) <= LIMIAR_ALERTA);
         end
      end

      assign atributos[i*W +: W] = val_q;
      assign alerta[i]           = alerta_q;
   end

   // death latches until reset; the prescaler and tick_seg keep running regardless
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_seg <= 1'b0;
         morreu   <= 1'b0;
      end else begin
         tick_seg <= tick;
         if (tick && !morreu && (|zera)) begin
            morreu <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_controlador_atributos_n.sv
// Bench for controlador_atributos_n: three instances (default, low VAL_INI, zero VAL_INI) checked every cycle
// against a per-second behavioural model, plus hand-computed checkpoints.
module tb_controlador_atributos_n;

   localparam int NA = 3;
   localparam int WW = 8;
   localparam int TK = 100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_v   [3];
   logic [2:0]        est_v   [3];
   logic [NA*WW-1:0]  attr_o  [3];
   logic [NA-1:0]     alert_o [3];
   logic              tick_o  [3];
   logic              dead_o  [3];

   int n_pass = 0;
   int n_tot  = 0;

   int ini_p [3] = '{100, 2, 0};
   int m_val [3][NA];
   int m_zc  [3][NA];
   int m_cnt [3];
   bit m_dead[3];
   bit m_tick[3];
   bit m_ok  [3];
   int tick_cnt[3];

   controlador_atributos_n dut_a (
      .clk(clk), .rst(rst_v[0]), .estado(est_v[0]),
      .atributos(attr_o[0]), .alerta(alert_o[0]), .tick_seg(tick_o[0]), .morreu(dead_o[0])
   );

   controlador_atributos_n #(.VAL_INI(2), .GRACA_SEG(3)) dut_b (
      .clk(clk), .rst(rst_v[1]), .estado(est_v[1]),
      .atributos(attr_o[1]), .alerta(alert_o[1]), .tick_seg(tick_o[1]), .morreu(dead_o[1])
   );

   controlador_atributos_n #(.VAL_INI(0)) dut_c (
      .clk(clk), .rst(rst_v[2]), .estado(est_v[2]),
      .atributos(attr_o[2]), .alerta(alert_o[2]), .tick_seg(tick_o[2]), .morreu(dead_o[2])
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      else n_pass++;
   endtask

   // Behavioural model: one "second" every TK cycles; recharge selected, decay the rest.
   always @(posedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (rst_v[d]) begin
            m_ok[d] = 1'b1; m_cnt[d] = 0; m_tick[d] = 1'b0; m_dead[d] = 1'b0;
            for (int i = 0; i < NA; i++) begin
               m_val[d][i] = ini_p[d];
               m_zc[d][i]  = 0;
            end
         end else if (m_ok[d]) begin
            m_tick[d] = (m_cnt[d] == TK - 1);
            m_cnt[d]  = (m_cnt[d] + 1) % TK;
            if (m_tick[d] && !m_dead[d]) begin
               for (int i = 0; i < NA; i++) begin
                  if (int'(est_v[d]) == i + 1) m_val[d][i] = (m_val[d][i] + 10 > 100) ? 100 : m_val[d][i] + 10;
                  else                         m_val[d][i] = (m_val[d][i] >= 1) ? m_val[d][i] - 1 : 0;
                  m_zc[d][i] = (m_val[d][i] == 0) ? ((m_zc[d][i] + 1 > 3) ? 3 : m_zc[d][i] + 1) : 0;
                  if (m_val[d][i] == 0 && m_zc[d][i] >= 3) m_dead[d] = 1'b1;
               end
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(posedge clk) begin
      logic [NA*WW-1:0] ea;
      logic [NA-1:0]    eal;
      #1;
      for (int d = 0; d < 3; d++) begin
         if (m_ok[d]) begin
            for (int i = 0; i < NA; i++) begin
               ea[i*WW +: WW] = WW'(m_val[d][i]);
               eal[i]         = (m_val[d][i] <= 20);
            end
            if (tick_o[d] === 1'b1) tick_cnt[d]++;
            chk($sformatf("model_attr%0d", d), 32'(attr_o[d]), 32'(ea));
            chk($sformatf("model_alerta%0d", d), 32'(alert_o[d]), 32'(eal));
            chk($sformatf("model_tick%0d", d), 32'(tick_o[d]), 32'(m_tick[d]));
            chk($sformatf("model_morreu%0d", d), 32'(dead_o[d]), 32'(m_dead[d]));
         end
      end
   end

   task automatic do_rst(input int d, input int n);
      @(negedge clk);
      rst_v[d] = 1'b1;
      repeat (n) @(negedge clk);
      rst_v[d] = 1'b0;
      tick_cnt[d] = 0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic scen_a();
      int c;
      int t0;
      do_rst(0, 2);
      est_v[0] = 3'd0;
      cycles(300);
      chk("a_idle_ticks", 32'(tick_cnt[0]), 32'd3);
      chk("a_idle_attr", 32'(attr_o[0]), 32'h616161);
      chk("a_idle_alerta", 32'(alert_o[0]), 32'd0);
      chk("a_idle_morreu", 32'(dead_o[0]), 32'd0);
      for (int k = 0; k < 300; k++) begin
         est_v[0] = ((k % 100) >= 30 && (k % 100) <= 60) ? 3'd2 : 3'd1;
         cycles(1);
      end
      chk("a_sono_attr", 32'(attr_o[0]), 32'h5E5E64);
      chk("a_sono_ticks", 32'(tick_cnt[0]), 32'd6);
      for (int s = 0; s < 30; s++) begin
         est_v[0] = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) do_rst(0, 1);
         cycles($urandom_range(1, 60) * 10);
      end
      est_v[0] = 3'd0;
      for (c = 0; c < 11000 && dead_o[0] !== 1'b1; c++) cycles(1);
      chk("a_death_reached", 32'(dead_o[0]), 32'd1);
      t0 = tick_cnt[0];
      cycles(250);
      chk("a_ticks_after_death", 32'(tick_cnt[0] - t0 >= 2), 32'd1);
      for (c = 0; c < 200 && tick_o[0] !== 1'b1; c++) cycles(1);
      cycles(37);
      rst_v[0] = 1'b1;
      cycles(1);
      rst_v[0] = 1'b0;
      chk("a_rst_attr", 32'(attr_o[0]), 32'h646464);
      chk("a_rst_morreu", 32'(dead_o[0]), 32'd0);
      chk("a_rst_tick", 32'(tick_o[0]), 32'd0);
      for (c = 1; c < 150; c++) begin
         cycles(1);
         if (tick_o[0] === 1'b1) break;
      end
      chk("a_first_tick_delay", 32'(c), 32'd100);
      cycles(99);
      rst_v[0] = 1'b1;
      cycles(1);
      rst_v[0] = 1'b0;
      chk("a_rst_beats_tick", 32'(tick_o[0]), 32'd0);
      cycles(150);
   endtask

   task automatic scen_b();
      do_rst(1, 2);
      est_v[1] = 3'd0;
      chk("b_rst_alerta", 32'(alert_o[1]), 32'h7);
      cycles(100);
      chk("b_tick1_attr", 32'(attr_o[1]), 32'h010101);
      chk("b_tick1_alerta", 32'(alert_o[1]), 32'h7);
      cycles(100);
      chk("b_tick2_attr", 32'(attr_o[1]), 32'h000000);
      cycles(300);
      chk("b_tick5_morreu", 32'(dead_o[1]), 32'd1);
      cycles(300);
      chk("b_tick8_attr", 32'(attr_o[1]), 32'h000000);
      chk("b_tick8_ticks", 32'(tick_cnt[1]), 32'd8);
      chk("b_tick8_morreu", 32'(dead_o[1]), 32'd1);
   endtask

   task automatic scen_c();
      do_rst(2, 2);
      est_v[2] = 3'd1;
      cycles(100);
      chk("c_recharge_attr", 32'(attr_o[2]), 32'h00000A);
      chk("c_recharge_alerta", 32'(alert_o[2]), 32'h7);
      est_v[2] = 3'd7;
      cycles(100);
      chk("c_code7_attr", 32'(attr_o[2]), 32'h000009);
      chk("c_code7_morreu", 32'(dead_o[2]), 32'd0);
      cycles(100);
      chk("c_tick3_attr", 32'(attr_o[2]), 32'h000008);
      chk("c_tick3_morreu", 32'(dead_o[2]), 32'd1);
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         rst_v[d]    = 1'b1;
         est_v[d]    = 3'd0;
         tick_cnt[d] = 0;
      end
      fork
         scen_a();
         scen_b();
         scen_c();
      join
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got running, expected finished");
      $fatal(1);
   end

endmodule
